// File: rtl/logic_proc_pkg.sv
// Shared types, code constants and the bitwise function helper for the
// serial logic sequencer.
package logic_proc_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } seq_state_t;

  localparam logic [2:0] F_AND  = 3'b000;
  localparam logic [2:0] F_OR   = 3'b001;
  localparam logic [2:0] F_XOR  = 3'b010;
  localparam logic [2:0] F_ONE  = 3'b011;
  localparam logic [2:0] F_NAND = 3'b100;
  localparam logic [2:0] F_NOR  = 3'b101;
  localparam logic [2:0] F_XNOR = 3'b110;
  localparam logic [2:0] F_ZERO = 3'b111;

  localparam logic [1:0] R_PASS = 2'b00;
  localparam logic [1:0] R_TO_B = 2'b01;
  localparam logic [1:0] R_TO_A = 2'b10;
  localparam logic [1:0] R_SWAP = 2'b11;

  function automatic logic bit_op(input logic [2:0] f, input logic a, input logic b);
    logic res;
    case (f)
      F_AND:   res = a & b;
      F_OR:    res = a | b;
      F_XOR:   res = a ^ b;
      F_ONE:   res = 1'b1;
      F_NAND:  res = ~(a & b);
      F_NOR:   res = ~(a | b);
      F_XNOR:  res = ~(a ^ b);
      F_ZERO:  res = 1'b0;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/compute_route.sv
// Zero-latency bitwise function and routing of the serial bits back into
// the MSBs of the two operand registers.
module compute_route
  import logic_proc_pkg::*;
(
  input  logic       a_out,
  input  logic       b_out,
  input  logic [2:0] f_sel,
  input  logic [1:0] r_sel,
  output logic       a_in,
  output logic       b_in
);

  logic f_bit;

  assign f_bit = bit_op(f_sel, a_out, b_out);

  // Route the function result and/or the operand LSBs to the MSB inputs.
  always_comb begin
    a_in = a_out;
    b_in = b_out;
    case (r_sel)
      R_PASS: begin a_in = a_out; b_in = b_out; end
      R_TO_B: begin a_in = a_out; b_in = f_bit; end
      R_TO_A: begin a_in = f_bit; b_in = b_out; end
      R_SWAP: begin a_in = b_out; b_in = a_out; end
      default: begin a_in = a_out; b_in = b_out; end
    endcase
  end

endmodule

// File: rtl/logic_sequencer.sv
// Sequencer for a WIDTH-cycle serial bitwise operation over two external
// right-shift registers: FSM, shift counter and captured F/R selects.
module logic_sequencer
  import logic_proc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Execute,
  input  logic       LoadA,
  input  logic       LoadB,
  input  logic [2:0] F,
  input  logic [1:0] R,
  input  logic       A_out,
  input  logic       B_out,
  output logic       Shift_En,
  output logic       Ld_A,
  output logic       Ld_B,
  output logic       A_In,
  output logic       B_In,
  output logic       Busy,
  output logic       Done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  seq_state_t    state;
  logic [CW-1:0] cnt;
  logic [2:0]    f_q;
  logic [1:0]    r_q;
  logic          shift_r;
  logic          done_r;
  logic          in_idle;

  // FSM, shift counter, operation capture and registered strobes.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      f_q     <= F_AND;
      r_q     <= R_PASS;
      shift_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          cnt    <= '0;
          // A pending load always takes priority over starting an operation.
          if (Execute && !LoadA && !LoadB) begin
            state   <= SHIFT;
            f_q     <= F;
            r_q     <= R;
            shift_r <= 1'b1;
          end else begin
            shift_r <= 1'b0;
          end
        end
        SHIFT: begin
          if (cnt == LAST) begin
            state   <= HOLD;
            cnt     <= '0;
            shift_r <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            cnt     <= cnt + {{(CW-1){1'b0}}, 1'b1};
            shift_r <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        HOLD: begin
          shift_r <= 1'b0;
          done_r  <= 1'b0;
          // Waiting for Execute to fall makes a held request run only once.
          if (!Execute) begin
            state <= IDLE;
          end else begin
            state <= HOLD;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          shift_r <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Load strobes pass through only while idle and out of reset.
  assign in_idle  = Reset_n && (state == IDLE);
  assign Ld_A     = in_idle && LoadA;
  assign Ld_B     = in_idle && LoadB;
  assign Shift_En = shift_r;
  assign Busy     = shift_r;
  assign Done     = done_r;

  compute_route u_compute_route (
    .a_out (A_out),
    .b_out (B_out),
    .f_sel (f_q),
    .r_sel (r_q),
    .a_in  (A_In),
    .b_in  (B_In)
  );

endmodule

// File: tb/tb_logic_sequencer.sv
// Directed bench for logic_sequencer with two 8-bit right-shift registers
// attached as the plant being sequenced.
module tb_logic_sequencer;

  localparam int W = 8;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Execute = 1'b0;
  logic       LoadA = 1'b0;
  logic       LoadB = 1'b0;
  logic [2:0] F = 3'b000;
  logic [1:0] R = 2'b00;
  logic       A_out, B_out;
  logic       Shift_En, Ld_A, Ld_B, A_In, B_In, Busy, Done;

  logic [W-1:0] a_reg = '0;
  logic [W-1:0] b_reg = '0;
  logic [W-1:0] a_load = '0;
  logic [W-1:0] b_load = '0;

  int n_cmp = 0;
  int n_fail = 0;

  logic_sequencer #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Execute  (Execute),
    .LoadA    (LoadA),
    .LoadB    (LoadB),
    .F        (F),
    .R        (R),
    .A_out    (A_out),
    .B_out    (B_out),
    .Shift_En (Shift_En),
    .Ld_A     (Ld_A),
    .Ld_B     (Ld_B),
    .A_In     (A_In),
    .B_In     (B_In),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 Clk = ~Clk;

  assign A_out = a_reg[0];
  assign B_out = b_reg[0];

  // Operand shift registers driven by the sequencer strobes.
  always @(posedge Clk) begin
    if (Ld_A) a_reg <= a_load;
    else if (Shift_En) a_reg <= {A_In, a_reg[W-1:1]};
    if (Ld_B) b_reg <= b_load;
    else if (Shift_En) b_reg <= {B_In, b_reg[W-1:1]};
  end

  task automatic do_op(input logic [2:0] f, input logic [1:0] r,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input int chg_at,
                       output int shifts, output int dones, output int max_run);
    int run;
    shifts = 0; dones = 0; max_run = 0; run = 0;
    @(negedge Clk);
    a_load = a; b_load = b; LoadA = 1'b1; LoadB = 1'b1;
    @(negedge Clk);
    LoadA = 1'b0; LoadB = 1'b0; F = f; R = r; Execute = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge Clk);
      if (i == 0) Execute = 1'b0;
      if (i == chg_at) begin F = 3'b111; R = 2'b00; end
      shifts += int'(Shift_En);
      dones  += int'(Done);
      run = Shift_En ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; LoadA = 1'b1; LoadB = 1'b1; Execute = 1'b1;
    #3;
    n_cmp++;
    if ({Shift_En, Busy, Done, Ld_A, Ld_B} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000", {Shift_En, Busy, Done, Ld_A, Ld_B});
    end
    repeat (2) @(negedge Clk);
    n_cmp++;
    if ({Shift_En, Busy, Done, Ld_A, Ld_B} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_held: got %b want 00000", {Shift_En, Busy, Done, Ld_A, Ld_B});
    end
    LoadA = 1'b0; LoadB = 1'b0;
  endtask

  task automatic test_exec_at_release();
    int shifts, dones;
    shifts = 0; dones = 0;
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge Clk);
      if (i == 0) begin
        Execute = 1'b0;
        n_cmp++;
        if (Shift_En !== 1'b1) begin
          n_fail++;
          $display("FAIL release_start: Shift_En got %b want 1", Shift_En);
        end
      end
      shifts += int'(Shift_En);
      dones  += int'(Done);
    end
    n_cmp++;
    if (shifts != 8 || dones != 1) begin
      n_fail++;
      $display("FAIL release_op: shifts/dones got %0d/%0d want 8/1", shifts, dones);
    end
  endtask

  task automatic test_functions();
    logic [2:0]   ft [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b010};
    logic [1:0]   rt [8] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00};
    logic [W-1:0] at [8] = '{8'hF0, 8'hC3, 8'h12, 8'h5A, 8'hF0, 8'h0F, 8'hCC, 8'h96};
    logic [W-1:0] bt [8] = '{8'hAA, 8'h5A, 8'h34, 8'h3C, 8'hAA, 8'h33, 8'hAA, 8'h69};
    logic [W-1:0] ea [8] = '{8'hA0, 8'hC3, 8'h34, 8'hFF, 8'hF0, 8'hC0, 8'h99, 8'h96};
    logic [W-1:0] eb [8] = '{8'hAA, 8'hDB, 8'h12, 8'h3C, 8'h5F, 8'h33, 8'hAA, 8'h69};
    int shifts, dones, max_run;
    for (int k = 0; k < 8; k++) begin
      do_op(ft[k], rt[k], at[k], bt[k], -1, shifts, dones, max_run);
      n_cmp++;
      if (max_run != 8 || shifts != 8 || dones != 1) begin
        n_fail++;
        $display("FAIL func%0d_timing: run/shifts/dones got %0d/%0d/%0d want 8/8/1", k, max_run, shifts, dones);
      end
      n_cmp++;
      if (a_reg !== ea[k] || b_reg !== eb[k]) begin
        n_fail++;
        $display("FAIL func%0d_result: A/B got %h/%h want %h/%h", k, a_reg, b_reg, ea[k], eb[k]);
      end
    end
  endtask

  task automatic test_f_change();
    int shifts, dones, max_run;
    do_op(3'b010, 2'b10, 8'h0F, 8'hFF, 2, shifts, dones, max_run);
    n_cmp++;
    if (a_reg !== 8'hF0 || b_reg !== 8'hFF || shifts != 8) begin
      n_fail++;
      $display("FAIL f_change: A/B/shifts got %h/%h/%0d want f0/ff/8", a_reg, b_reg, shifts);
    end
  endtask

  task automatic test_held_execute();
    int shifts, dones;
    shifts = 0; dones = 0;
    @(negedge Clk);
    Execute = 1'b1; F = 3'b000; R = 2'b00;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      shifts += int'(Shift_En);
      dones  += int'(Done);
    end
    n_cmp++;
    if (shifts != 8 || dones != 1) begin
      n_fail++;
      $display("FAIL held_execute: shifts/dones got %0d/%0d want 8/1", shifts, dones);
    end
    Execute = 1'b0;
    repeat (2) @(negedge Clk);
    n_cmp++;
    if (Shift_En !== 1'b0) begin
      n_fail++;
      $display("FAIL held_release: Shift_En got %b want 0", Shift_En);
    end
    Execute = 1'b1;
    @(negedge Clk);
    Execute = 1'b0;
    n_cmp++;
    if (Shift_En !== 1'b1) begin
      n_fail++;
      $display("FAIL held_rearm: Shift_En got %b want 1", Shift_En);
    end
    repeat (12) @(negedge Clk);
  endtask

  task automatic test_reset_mid();
    int shifts, dones, max_run;
    dones = 0;
    @(negedge Clk);
    Execute = 1'b1;
    for (int i = 0; i < 4; i++) @(negedge Clk);
    Execute = 1'b0;
    #2 Reset_n = 1'b0;
    #1;
    n_cmp++;
    if (Shift_En !== 1'b0 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: Shift_En/Busy got %b/%b want 0/0", Shift_En, Busy);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      dones += int'(Done);
    end
    n_cmp++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL reset_mid_done: dones got %0d want 0", dones);
    end
    do_op(3'b000, 2'b10, 8'hF0, 8'hAA, -1, shifts, dones, max_run);
    n_cmp++;
    if (max_run != 8 || dones != 1 || a_reg !== 8'hA0) begin
      n_fail++;
      $display("FAIL reset_mid_next: run/dones/A got %0d/%0d/%h want 8/1/a0", max_run, dones, a_reg);
    end
  endtask

  task automatic test_load_priority();
    int shifts;
    shifts = 0;
    @(negedge Clk);
    a_load = 8'h5C; LoadA = 1'b1; Execute = 1'b1;
    #1;
    n_cmp++;
    if (Ld_A !== 1'b1 || Ld_B !== 1'b0) begin
      n_fail++;
      $display("FAIL load_strobe: Ld_A/Ld_B got %b/%b want 1/0", Ld_A, Ld_B);
    end
    @(negedge Clk);
    n_cmp++;
    if (Shift_En !== 1'b0 || Ld_A !== 1'b1 || a_reg !== 8'h5C) begin
      n_fail++;
      $display("FAIL load_wins: Shift_En/Ld_A/A got %b/%b/%h want 0/1/5c", Shift_En, Ld_A, a_reg);
    end
    LoadA = 1'b0;
    @(negedge Clk);
    Execute = 1'b0;
    n_cmp++;
    if (Shift_En !== 1'b1) begin
      n_fail++;
      $display("FAIL load_then_start: Shift_En got %b want 1", Shift_En);
    end
    LoadA = 1'b1; LoadB = 1'b1;
    #1;
    n_cmp++;
    if (Ld_A !== 1'b0 || Ld_B !== 1'b0) begin
      n_fail++;
      $display("FAIL load_masked: Ld_A/Ld_B got %b/%b want 0/0", Ld_A, Ld_B);
    end
    LoadA = 1'b0; LoadB = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      shifts += int'(Shift_En);
    end
    n_cmp++;
    if (shifts != 7) begin
      n_fail++;
      $display("FAIL load_op_len: remaining shifts got %0d want 7", shifts);
    end
  endtask

  initial begin
    test_reset();
    test_exec_at_release();
    test_functions();
    test_f_change();
    test_held_execute();
    test_reset_mid();
    test_load_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_sequencer.md
LOGIC_SEQUENCER -- requirements
Module: logic_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: bit length of each operand register and the number of shift cycles per operation.
REQ-002 Single clock, Clk; reset is asynchronous and active-low, Reset_n; the polarity and synchronicity are fixed.
REQ-003 Clk  in  1  rising-edge clock for all state.
REQ-004 Reset_n  in  1  asynchronous active-low reset.
REQ-005 Execute  in  1  level request to run one operation; synchronous to Clk.
REQ-006 LoadA, LoadB  in  1 each  parallel-load requests for operand registers A and B.
REQ-007 F  in  3  bitwise function select.
REQ-008 R  in  2  result routing select.
REQ-009 A_out, B_out  in  1 each  serial LSB currently presented by registers A and B.
REQ-010 Shift_En  out  1  shift-right strobe to both registers.
REQ-011 Ld_A, Ld_B  out  1 each  parallel-load strobes to registers A and B.
REQ-012 A_In, B_In  out  1 each  serial bits entering the MSB of A and B.
REQ-013 Busy  out  1  high while shifting.
REQ-014 Done  out  1  one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT, HOLD.
REQ-016 IDLE->SHIFT SHALL occur when Execute=1, LoadA=0 and LoadB=0; F and R SHALL be captured into F_q/R_q on this edge.
REQ-017 SHIFT SHALL last exactly WIDTH cycles, counted by a clog2(WIDTH)-bit counter from 0 to WIDTH-1, then go to HOLD.
REQ-018 Shift_En SHALL equal 1 in SHIFT and 0 otherwise; Busy SHALL equal Shift_En.
REQ-019 Done SHALL be 1 for exactly the first cycle of HOLD.
REQ-020 HOLD->IDLE SHALL occur only when Execute=0, so a held Execute yields exactly one operation.
REQ-021 F_q codes SHALL be: 000 AND, 001 OR, 010 XOR, 011 one, 100 NAND, 101 NOR, 110 XNOR, 111 zero; result bit f = op(A_out,B_out).
REQ-022 R_q codes SHALL be: 00 A_In=A_out, B_In=B_out; 01 A_In=A_out, B_In=f; 10 A_In=f, B_In=B_out; 11 A_In=B_out, B_In=A_out.
REQ-023 A_In/B_In SHALL be combinational from A_out, B_out, F_q and R_q, with zero latency.
REQ-024 Changes to F or R while in SHIFT or HOLD SHALL NOT affect the running operation.
REQ-025 Ld_A SHALL equal LoadA and Ld_B SHALL equal LoadB in IDLE only; both SHALL be 0 in SHIFT and HOLD.
REQ-026 When Execute and a load request are both high in IDLE, the load SHALL win and the state SHALL remain IDLE.

Reset
REQ-027 Reset_n=0 SHALL immediately force state IDLE, counter 0, F_q=000 and R_q=00, without waiting for Clk.
REQ-028 During reset, Shift_En, Busy, Done, Ld_A and Ld_B SHALL be 0.
REQ-029 If Execute is high when reset is released, an operation SHALL start on the first clock edge after release.
REQ-030 Reset asserted mid-SHIFT SHALL abandon the operation with no Done pulse; the next operation SHALL run a full WIDTH cycles.

Structure
REQ-031 A shared package logic_proc_pkg SHALL hold the state enum, the F and R code constants, and the default WIDTH.
REQ-032 The combinational function and routing logic SHALL be a sub-module named compute_route; the FSM and counter SHALL live in logic_sequencer.

Verification (the bench models two WIDTH-bit right-shift registers)
REQ-033 A=F0h, B=AAh, F=000, R=10, Execute pulse -> Shift_En high 8 consecutive cycles, then A=A0h, B=AAh, Done high 1 cycle.
REQ-034 A=12h, B=34h, R=11 -> A=34h, B=12h after 8 shifts.
REQ-035 F switched from 010 to 111 at shift cycle 3, starting with A=0Fh, B=FFh, R=10 -> A=F0h (XOR result), so the switch is ignored.
REQ-036 Execute held high for 20 cycles -> exactly one 8-cycle shift burst and one Done; the next burst starts only after Execute falls and rises again.
REQ-037 Reset_n pulled low at shift cycle 4 -> Shift_En and Busy drop to 0 asynchronously and no Done; the next Execute yields a full 8 shifts.
REQ-038 LoadA=1 with Execute=1 in IDLE -> Ld_A=1, Shift_En=0, state stays IDLE; releasing LoadA starts the shift on the next edge.
